// File: rtl/axis_sync_fifo_if.sv
// AXI-Stream bus bundle for axis_sync_fifo: write side (s_axis) and read side (m_axis).
// The slave modport is the FIFO's view; master is the view of the surrounding logic.
interface axis_sync_fifo_if #(
    parameter int p_data_width = 8
);
    logic [p_data_width-1:0] i_s_axis_tdata;
    logic                    i_s_axis_tvalid;
    logic                    o_s_axis_tready;
    logic [p_data_width-1:0] o_m_axis_tdata;
    logic                    o_m_axis_tvalid;
    logic                    i_m_axis_tready;

    modport slave (
        input  i_s_axis_tdata,
        input  i_s_axis_tvalid,
        output o_s_axis_tready,
        output o_m_axis_tdata,
        output o_m_axis_tvalid,
        input  i_m_axis_tready
    );

    modport master (
        output i_s_axis_tdata,
        output i_s_axis_tvalid,
        input  o_s_axis_tready,
        input  o_m_axis_tdata,
        input  o_m_axis_tvalid,
        output i_m_axis_tready
    );
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through AXI-Stream FIFO, 2**p_addr_width entries.
// Status flags and handshakes are decoded from a registered fill count; storage is not reset.
module axis_sync_fifo #(
    parameter int p_data_width = 8,
    parameter int p_addr_width = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_sclr,
    axis_sync_fifo_if.slave       bus,
    output logic [p_addr_width:0] o_count,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int DEPTH = 1 << p_addr_width;
    localparam logic [p_addr_width:0] FULL_CNT = (p_addr_width + 1)'(DEPTH);

    logic [p_data_width-1:0] mem_q [DEPTH];
    logic [p_addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [p_addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [p_addr_width:0]   count_q, count_d;
    logic                    push, pop;

    // Flags come straight off the registered count so they are glitch-free and
    // fall to their reset values as soon as the async reset hits the count.
    assign o_count             = count_q;
    assign o_full              = (count_q == FULL_CNT);
    assign o_empty             = (count_q == '0);
    assign bus.o_s_axis_tready = !o_full;
    assign bus.o_m_axis_tvalid = !o_empty;
    assign bus.o_m_axis_tdata  = mem_q[rd_ptr_q];

    // A full FIFO refuses writes even when a pop frees a slot this cycle.
    assign push = bus.i_s_axis_tvalid && !o_full;
    assign pop  = bus.i_m_axis_tready && !o_empty;

    // Next-state pointers and count; a flush overrides any transfer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_sclr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; a push during a flush lands in a slot the flush abandons.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.i_s_axis_tdata;
    end
endmodule

// File: tb/tb_axis_sync_fifo.sv
// Randomized bench for axis_sync_fifo against a queue-based model of the FIFO.
module tb_axis_sync_fifo;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sclr = 1'b0;
    logic [AW:0]   count;
    logic          full, empty;
    logic [DW-1:0] q[$];
    int            errors = 0;
    int            checks = 0;

    axis_sync_fifo_if #(.p_data_width(DW)) bus ();

    axis_sync_fifo #(.p_data_width(DW), .p_addr_width(AW)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_sclr    (sclr),
        .bus       (bus.slave),
        .o_count   (count),
        .o_full    (full),
        .o_empty   (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every DUT output against the model's current contents.
    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".s_rdy"}, 32'(bus.o_s_axis_tready), 32'(q.size() != DEPTH));
        chk({tag, ".m_vld"}, 32'(bus.o_m_axis_tvalid), 32'(q.size() != 0));
        if (q.size() != 0) chk({tag, ".data"}, 32'(bus.o_m_axis_tdata), 32'(q[0]));
    endtask

    // One clock: drive on the falling edge, update the model at the rising edge, check 1ns later.
    task automatic step(input string tag, input logic vld, input logic [DW-1:0] d,
                        input logic rdy, input logic clr);
        int n;
        @(negedge clk);
        bus.i_s_axis_tvalid = vld;
        bus.i_s_axis_tdata  = d;
        bus.i_m_axis_tready = rdy;
        sclr                = clr;
        @(posedge clk);
        n = q.size();
        if (clr) q.delete();
        else begin
            if (rdy && n > 0) void'(q.pop_front());
            if (vld && n < DEPTH) q.push_back(d);
        end
        #1;
        chk_state(tag);
    endtask

    initial begin
        logic [DW-1:0] d;
        bus.i_s_axis_tvalid = 1'b0;
        bus.i_s_axis_tdata  = '0;
        bus.i_m_axis_tready = 1'b0;

        // Reset values while held in reset.
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single word falls through and holds while downstream stalls.
        step("one_push", 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("one_head", 32'(bus.o_m_axis_tdata), 32'hA5);
        for (int i = 0; i < 5; i++) begin
            step("hold", 1'b0, 8'(i), 1'b0, 1'b0);
            chk("hold_data", 32'(bus.o_m_axis_tdata), 32'hA5);
        end
        step("drain1", 1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to full, overflow attempt, drain in order.
        for (int i = 0; i < 16; i++) step("fill16", 1'b1, 8'(i), 1'b0, 1'b0);
        chk("full_flag", 32'(full), 32'd1);
        step("overflow", 1'b1, 8'hEE, 1'b0, 1'b0);
        chk("overflow_cnt", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 32'(bus.o_m_axis_tdata), 32'(i));
            step("drain16", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drained_empty", 32'(empty), 32'd1);

        // Steady-state streaming at level 8 with pointer wrap.
        for (int i = 0; i < 8; i++) step("fill8", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step("stream", 1'b1, 8'(8'h48 + i), 1'b1, 1'b0);
        chk("stream_cnt", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) step("stream_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Full with push+pop: pop happens, push ignored.
        for (int i = 0; i < 16; i++) step("refill", 1'b1, 8'(i), 1'b0, 1'b0);
        step("full_both", 1'b1, 8'h77, 1'b1, 1'b0);
        chk("full_both_cnt", 32'(count), 32'd15);
        chk("full_both_head", 32'(bus.o_m_axis_tdata), 32'h01);

        // Flush overrides simultaneous push/pop.
        step("flush", 1'b1, 8'h99, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step("fill5", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step("flush5", 1'b1, 8'h99, 1'b1, 1'b1);
        chk("flush_cnt", 32'(count), 32'd0);
        step("post_flush", 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_flush_head", 32'(bus.o_m_axis_tdata), 32'h3C);
        step("pf_drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset pulse between edges with 10 words stored.
        for (int i = 0; i < 10; i++) step("fill10", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        bus.i_s_axis_tvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk_state("async_rst");
        #2 rst_n = 1'b1;
        step("after_rst", 1'b0, 8'h00, 1'b1, 1'b0);
        step("after_rst_push", 1'b1, 8'h5A, 1'b0, 1'b0);

        // Random traffic with phases biased toward filling and draining.
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 60; i++) begin
                d = 8'($urandom);
                step("rand",
                     ($urandom_range(0, 9) < ((ph % 2 == 0) ? 8 : 3)),
                     d,
                     ($urandom_range(0, 9) < ((ph % 2 == 0) ? 3 : 8)),
                     ($urandom_range(0, 63) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
